// File: rtl/hazard_mdscore_pkg.sv
// Shared constants and state encoding for the hazard unit with MD scoreboard.
package hazard_pkg;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {IDLE, BUSY} md_state_t;
endpackage

// File: rtl/hazard_mdscore_if.sv
// Datapath <-> hazard unit signal bundle; slave is the hazard unit side.
interface hazard_mdscore_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic              MdStartD;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [1:0]        ResultSrcE;
    logic              MdStartE;
    logic              PCSrcE;
    logic [REG_AW-1:0] RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, FlushD, FlushE;
    logic              MdBusy, MdWe;
    logic [REG_AW-1:0] MdRd;
    logic [CNT_W-1:0]  StallCount, FlushCount;

    modport slave (
        input  Rs1D, Rs2D, RdD, MdStartD, Rs1E, Rs2E, RdE, ResultSrcE, MdStartE,
               PCSrcE, RdM, RegWriteM, RdW, RegWriteW,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MdBusy, MdWe, MdRd, StallCount, FlushCount
    );
    modport master (
        output Rs1D, Rs2D, RdD, MdStartD, Rs1E, Rs2E, RdE, ResultSrcE, MdStartE,
               PCSrcE, RdM, RegWriteM, RdW, RegWriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MdBusy, MdWe, MdRd, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_mdscore_md_scoreboard.sv
// One-entry scoreboard for the fixed-latency MD unit: tracks the pending
// destination and raises the write-back strobe when the countdown expires.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] rd_in,
    output logic              busy,
    output logic              we,
    output logic [REG_AW-1:0] rd
);
    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

    md_state_t         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [REG_AW-1:0] rd_n;
    logic              ovl, ovl_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rd    <= '0;
            ovl   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rd    <= rd_n;
            ovl   <= ovl_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = rd;
        ovl_n   = ovl;
        case (state)
            IDLE: if (start) begin
                state_n = BUSY;
                cnt_n   = CW'(MD_LAT - 1);
                rd_n    = rd_in;
            end
            BUSY: if (cnt == '0) begin
                // A new issue in the write-back cycle chains straight on
                if (start) begin
                    cnt_n = CW'(MD_LAT - 1);
                    rd_n  = rd_in;
                end else begin
                    state_n = IDLE;
                end
            end else begin
                cnt_n = cnt - 1'b1;
                if (start) ovl_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign we   = busy && (cnt == '0);

    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !ovl);
endmodule

// File: rtl/hazard_mdscore.sv
// Hazard unit: E-stage forwarding, load-use / MD stalls, branch flush,
// MD scoreboard and saturating stall/flush counters.
module hazard_mdscore
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input logic             clk,
    input logic             rst,
    hazard_mdscore_if.slave hz
);
    logic              md_busy, md_we;
    logic [REG_AW-1:0] md_rd;
    logic              lw_stall, md_stall, stall;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && hz.RegWriteM && rs == hz.RdM)      return FWD_M;
        else if (rs != '0 && hz.RegWriteW && rs == hz.RdW) return FWD_W;
        else                                               return FWD_RF;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.Rs1E);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E);

    assign lw_stall = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != '0) &&
                      (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);

    // RdD is included so a younger writer cannot land before the MD result (WAW)
    assign md_stall =
        (hz.MdStartE && hz.RdE != '0 &&
         (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D || hz.RdE == hz.RdD)) ||
        (md_busy && !md_we && md_rd != '0 &&
         (md_rd == hz.Rs1D || md_rd == hz.Rs2D || md_rd == hz.RdD)) ||
        (hz.MdStartD && (hz.MdStartE || (md_busy && !md_we)));

    assign stall     = (lw_stall || md_stall) && !hz.PCSrcE;
    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushD = hz.PCSrcE;
    assign hz.FlushE = stall || hz.PCSrcE;

    md_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .start (hz.MdStartE),
        .rd_in (hz.RdE),
        .busy  (md_busy),
        .we    (md_we),
        .rd    (md_rd)
    );

    assign hz.MdBusy = md_busy;
    assign hz.MdWe   = md_we;
    assign hz.MdRd   = md_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
            if (hz.PCSrcE && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;
endmodule

// File: tb/tb_hazard_mdscore.sv
// Directed bench for hazard_mdscore; a CNT_W=4 twin shares the stimulus to
// exercise counter saturation.
module tb_hazard_mdscore;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_mdscore_if #(.REG_AW(5), .CNT_W(32)) hz ();
    hazard_mdscore_if #(.REG_AW(5), .CNT_W(4))  hz4 ();

    hazard_mdscore #(.REG_AW(5), .MD_LAT(4), .CNT_W(32)) dut (
        .clk (clk), .rst (rst), .hz (hz.slave));
    hazard_mdscore #(.REG_AW(5), .MD_LAT(4), .CNT_W(4)) dut4 (
        .clk (clk), .rst (rst), .hz (hz4.slave));

    assign hz4.Rs1D = hz.Rs1D;       assign hz4.Rs2D = hz.Rs2D;
    assign hz4.RdD = hz.RdD;         assign hz4.MdStartD = hz.MdStartD;
    assign hz4.Rs1E = hz.Rs1E;       assign hz4.Rs2E = hz.Rs2E;
    assign hz4.RdE = hz.RdE;         assign hz4.ResultSrcE = hz.ResultSrcE;
    assign hz4.MdStartE = hz.MdStartE; assign hz4.PCSrcE = hz.PCSrcE;
    assign hz4.RdM = hz.RdM;         assign hz4.RegWriteM = hz.RegWriteM;
    assign hz4.RdW = hz.RdW;         assign hz4.RegWriteW = hz.RegWriteW;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0; hz.MdStartD = 1'b0;
        hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0; hz.ResultSrcE = 2'b00;
        hz.MdStartE = 1'b0; hz.PCSrcE = 1'b0;
        hz.RdM = '0; hz.RegWriteM = 1'b0; hz.RdW = '0; hz.RegWriteW = 1'b0;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stallf"}, 32'(hz.StallF), 32'(exp));
        chk({tag, "_stalld"}, 32'(hz.StallD), 32'(exp));
    endtask

    initial begin
        clr();
        // Reset state
        tick();
        chk("rst_busy", 32'(hz.MdBusy), 32'd0);
        chk("rst_we", 32'(hz.MdWe), 32'd0);
        chk("rst_mdrd", 32'(hz.MdRd), 32'd0);
        chk("rst_scnt", hz.StallCount, 32'd0);
        chk("rst_fcnt", hz.FlushCount, 32'd0);
        #2 rst = 1'b0;
        tick();

        // Forwarding
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        #1 chk("fwd_a_m", 32'(hz.ForwardAE), 32'(FWD_M));
        chk("fwd_b_rf", 32'(hz.ForwardBE), 32'(FWD_RF));
        hz.Rs1E = 5'd0;
        #1 chk("fwd_a_x0", 32'(hz.ForwardAE), 32'(FWD_RF));
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd7; hz.RdW = 5'd7;
        #1 chk("fwd_b_w", 32'(hz.ForwardBE), 32'(FWD_W));
        chk("fwd_a_keep", 32'(hz.ForwardAE), 32'(FWD_M));
        hz.RegWriteM = 1'b0; hz.RdW = 5'd5; hz.Rs2E = 5'd5; hz.RegWriteW = 1'b0;
        #1 chk("fwd_a_nowe", 32'(hz.ForwardAE), 32'(FWD_RF));
        hz.RegWriteW = 1'b1;
        #1 chk("fwd_a_w", 32'(hz.ForwardAE), 32'(FWD_W));
        chk("fwd_b_w2", 32'(hz.ForwardBE), 32'(FWD_W));
        clr();

        // Load-use stall
        tick();
        hz.ResultSrcE = RES_LOAD; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
        #1 chk_stall("lw", 1'b1);
        chk("lw_flushe", 32'(hz.FlushE), 32'd1);
        chk("lw_flushd", 32'(hz.FlushD), 32'd0);
        tick();
        clr();
        #1 chk("lw_scnt", hz.StallCount, 32'd1);
        chk_stall("lw_rel", 1'b0);
        hz.ResultSrcE = RES_LOAD; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
        #1 chk_stall("lw_x0", 1'b0);
        tick();
        clr();
        #1 chk("lw_x0_scnt", hz.StallCount, 32'd1);

        // MD RAW: issue at t, consumer held in D
        hz.MdStartE = 1'b1; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
        #1 chk_stall("md_t0", 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            hz.MdStartE = 1'b0; hz.RdE = 5'd0;
            #1 chk_stall($sformatf("md_t%0d", i), 1'b1);
            chk($sformatf("md_busy_t%0d", i), 32'(hz.MdBusy), 32'd1);
            chk($sformatf("md_we_t%0d", i), 32'(hz.MdWe), 32'd0);
        end
        tick();
        chk("md_we_t4", 32'(hz.MdWe), 32'd1);
        chk("md_rd_t4", 32'(hz.MdRd), 32'd9);
        chk("md_busy_t4", 32'(hz.MdBusy), 32'd1);
        chk_stall("md_t4", 1'b0);
        tick();
        clr();
        #1 chk("md_busy_t5", 32'(hz.MdBusy), 32'd0);
        chk("md_we_t5", 32'(hz.MdWe), 32'd0);
        chk("md_scnt", hz.StallCount, 32'd5);

        // Structural hazard, then chained issue in the write-back cycle
        hz.MdStartE = 1'b1; hz.RdE = 5'd10;
        hz.MdStartD = 1'b1; hz.Rs1D = 5'd1; hz.Rs2D = 5'd2; hz.RdD = 5'd11;
        #1 chk_stall("st_t0", 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            hz.MdStartE = 1'b0; hz.RdE = 5'd0;
            #1 chk_stall($sformatf("st_t%0d", i), 1'b1);
        end
        tick();
        hz.MdStartD = 1'b0; hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0;
        hz.MdStartE = 1'b1; hz.RdE = 5'd11;
        #1 chk("st_we_t4", 32'(hz.MdWe), 32'd1);
        chk("st_rd_t4", 32'(hz.MdRd), 32'd10);
        chk_stall("st_t4", 1'b0);
        tick();
        clr();
        #1 chk("st_busy_t5", 32'(hz.MdBusy), 32'd1);
        chk("st_we_t5", 32'(hz.MdWe), 32'd0);
        chk("st_rd_t5", 32'(hz.MdRd), 32'd11);
        chk("st_scnt", hz.StallCount, 32'd9);
        tick(); tick(); tick();
        chk("st_we_t8", 32'(hz.MdWe), 32'd1);
        chk("st_rd_t8", 32'(hz.MdRd), 32'd11);
        tick();
        chk("st_busy_t9", 32'(hz.MdBusy), 32'd0);

        // Branch wins over load-use stall
        hz.ResultSrcE = RES_LOAD; hz.RdE = 5'd3; hz.Rs1D = 5'd3; hz.PCSrcE = 1'b1;
        #1 chk_stall("br", 1'b0);
        chk("br_flushd", 32'(hz.FlushD), 32'd1);
        chk("br_flushe", 32'(hz.FlushE), 32'd1);
        tick();
        clr();
        #1 chk("br_fcnt", hz.FlushCount, 32'd1);
        chk("br_scnt", hz.StallCount, 32'd9);

        // Asynchronous reset mid MD op
        hz.MdStartE = 1'b1; hz.RdE = 5'd12;
        tick();
        clr();
        tick();
        chk("ar_busy_pre", 32'(hz.MdBusy), 32'd1);
        #2 rst = 1'b1;
        #1 chk("ar_busy", 32'(hz.MdBusy), 32'd0);
        chk("ar_we", 32'(hz.MdWe), 32'd0);
        chk("ar_mdrd", 32'(hz.MdRd), 32'd0);
        chk("ar_scnt", hz.StallCount, 32'd0);
        chk("ar_fcnt", hz.FlushCount, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ar_we_hold%0d", i), 32'(hz.MdWe), 32'd0);
        end
        #2 rst = 1'b0;
        tick();
        chk("ar_busy_post", 32'(hz.MdBusy), 32'd0);
        chk("ar_we_post", 32'(hz.MdWe), 32'd0);

        // 20 stall cycles: wide counter counts, 4-bit counter saturates
        hz.ResultSrcE = RES_LOAD; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
        for (int i = 0; i < 20; i++) tick();
        clr();
        #1 chk("sat_scnt32", hz.StallCount, 32'd20);
        chk("sat_scnt4", 32'(hz4.StallCount), 32'd15);
        chk("sat_fcnt4", 32'(hz4.FlushCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_mdscore.md
# hazard_mdscore

Next-generation hazard unit for the 5-stage RV32 pipeline. Keeps the E-stage forwarding, load-use stall and branch flush. Adds three things: a one-entry scoreboard for a fixed-latency multi-cycle mul/div unit (MD), correct stall/flush priority, and saturating stall/flush performance counters. It sits beside the datapath, observes D/E/M/W register fields, and drives the stall, flush and forward controls plus the MD write-back strobe.

## Interface
- REG_AW, 5, register-index width
- MD_LAT, 4, MD latency in cycles (≥2)
- CNT_W, 32, performance-counter width
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D, RdD  in  REG_AW  D-stage source/destination indices
- MdStartD  in  1  D-stage instruction is an MD op
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage indices
- ResultSrcE  in  2  E-stage result select; 2'b01 = load
- MdStartE  in  1  E-stage instruction is an MD op (issues to unit)
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RegWriteM  in  REG_AW, 1  M-stage writer
- RdW, RegWriteW  in  REG_AW, 1  W-stage writer
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W, 10 M
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls
- MdBusy  out  1  scoreboard entry valid
- MdWe  out  1  MD result write-back strobe (regfile second write port)
- MdRd  out  REG_AW  MD destination
- StallCount, FlushCount  out  CNT_W  saturating counters

## Operation
- Forwarding is combinational, per operand. Priority: M (10) if RsXE==RdM, RegWriteM and RsXE≠0; else W (01) if RsXE==RdW, RegWriteW and RsXE≠0; else 00. The A and B paths are independent and each drives only its own output.
- MD ops travel the main pipeline with RegWrite=0, so they are never forwarded. Consumers of an MD result wait for MdWe.
- lwStall = (ResultSrcE==01) & RdE≠0 & (Rs1D==RdE | Rs2D==RdE).
- mdStall is the OR of:
  - MdStartE & RdE≠0 & RdE∈{Rs1D,Rs2D,RdD}
  - MdBusy & ~MdWe & MdRd≠0 & MdRd∈{Rs1D,Rs2D,RdD} (RAW and WAW)
  - MdStartD & (MdStartE | (MdBusy & ~MdWe)) (structural)
- stall = (lwStall | mdStall) & ~PCSrcE. StallF = StallD = stall.
- FlushD = PCSrcE. FlushE = stall | PCSrcE.
- Scoreboard FSM, states IDLE and BUSY:
  - IDLE→BUSY on MdStartE: load MdRd=RdE and cnt=MD_LAT-1.
  - In BUSY, cnt decrements each cycle. MdWe=1 when cnt==0.
  - In BUSY with cnt==0: next state is IDLE, unless MdStartE is asserted the same cycle, in which case reload and stay in BUSY.
  - MdStartE in BUSY with cnt≠0 is impossible under correct stalling. The unit ignores it and sets a sticky internal overlap flag for assertions.
- StallCount increments on every cycle with StallD=1. FlushCount increments on every cycle with PCSrcE=1. Both saturate at all-ones.

## Timing
- Reset values: all scoreboard and counter state is 0, FSM is IDLE, MdBusy=MdWe=0, MdRd=0, StallCount=FlushCount=0. Combinational outputs follow their inputs during reset.
- MdStartE in cycle t gives MdBusy=1 in cycles t+1…t+MD_LAT and MdWe=1 in cycle t+MD_LAT only.
- The register file writes on the falling edge, so the RAW stall releases in the MdWe cycle and D reads the new value that same cycle.
- rst asserted mid-operation drops MdBusy immediately (asynchronous) with no MdWe pulse. The in-flight result is lost, which is intended on reset.
- Branch plus any stall in the same cycle: the flush wins. StallF=0 so the target is fetched. The counters record the flush, not a stall.

## Structure
- Package hazard_pkg holds:
  - constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, RES_LOAD=2'b01
  - typedef md_state_t {IDLE, BUSY}
- One sub-module, md_scoreboard: FSM, countdown, MdRd register and overlap flag. Forwarding, stall/flush logic and counters stay in the top level.

## Test plan
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Same with Rs1E=0 → 00. Rs2E=7, RdW=7 → ForwardBE=01 with ForwardAE unaffected.
- ResultSrcE=01, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle, StallCount +1. Same with RdE=0 → no stall.
- MdStartE, RdE=9 at t (MD_LAT=4), Rs1D=9 held in D → stall t..t+3, MdWe and MdRd=9 at t+4, stall released at t+4, MdBusy=0 at t+5.
- Back-to-back MdStartD while an MD op is in E → D stalls until the MdWe cycle. MdStartE in the MdWe cycle reloads with MdBusy continuous.
- lwStall and PCSrcE in the same cycle → StallF=StallD=0, FlushD=FlushE=1, FlushCount +1, StallCount unchanged.
- rst pulsed at t+2 of an MD op → MdBusy=0 asynchronously, no MdWe. With CNT_W=4 and 20 stall cycles → StallCount=15.
